bf_scan_scheduler: RTL and testbench

- Sequences the delay-and-sum beamformer over a rectangular grid of focal points: one frame = NUM_X columns × NUM_Z depths.
- For each point it clears the beamformer, drives x_f/z_f, pulses start and waits for valid, with a watchdog.
- Each result is emitted as a pixel on a ready/valid stream to the downstream image buffer.
- Sits directly above the beamformer core and is the only block driving its start, coordinates and clear.

---
 rtl/bf_pkg.sv | 22 ++
 rtl/bf_grid_counter.sv | 72 +++++++
 rtl/bf_scan_scheduler.sv | 161 ++++++++++++++++
 tb/tb_bf_scan_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the beamformer scan scheduler: coordinate width,
// scheduler state encoding and an index-width helper for the pixel bundle.
package bf_pkg;

  localparam int COORD_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT    = 3'd3,
    S_EMIT    = 3'd4,
    S_ADVANCE = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  // A one-entry axis still needs a 1-bit index field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bf_grid_counter.sv
// Nested scan counters: z is the inner (depth) loop, x the outer (column)
// loop, each with a 16-bit wrapping focal-coordinate accumulator.
module bf_grid_counter
  import bf_pkg::*;
#(
  parameter int                      NUM_X   = 64,
  parameter int                      NUM_Z   = 128,
  parameter logic [COORD_WIDTH-1:0]  X_START = 16'd0,
  parameter logic [COORD_WIDTH-1:0]  X_STEP  = 16'd1,
  parameter logic [COORD_WIDTH-1:0]  Z_START = 16'd0,
  parameter logic [COORD_WIDTH-1:0]  Z_STEP  = 16'd1,
  localparam int                     XW      = idx_w(NUM_X),
  localparam int                     ZW      = idx_w(NUM_Z)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic                   i_step,
  output logic [XW-1:0]          o_xi,
  output logic [ZW-1:0]          o_zi,
  output logic [COORD_WIDTH-1:0] o_x_f,
  output logic [COORD_WIDTH-1:0] o_z_f,
  output logic                   o_last
);

  localparam logic [XW-1:0] X_LAST = XW'(NUM_X - 1);
  localparam logic [ZW-1:0] Z_LAST = ZW'(NUM_Z - 1);

  logic [XW-1:0]          r_xi;
  logic [ZW-1:0]          r_zi;
  logic [COORD_WIDTH-1:0] r_x_f;
  logic [COORD_WIDTH-1:0] r_z_f;
  logic                   w_x_last;
  logic                   w_z_last;

  assign w_x_last = (r_xi == X_LAST);
  assign w_z_last = (r_zi == Z_LAST);

  // On the final point the depth loop still rewinds; x is simply held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xi  <= '0;
      r_zi  <= '0;
      r_x_f <= X_START;
      r_z_f <= Z_START;
    end else if (i_load) begin
      r_xi  <= '0;
      r_zi  <= '0;
      r_x_f <= X_START;
      r_z_f <= Z_START;
    end else if (i_step) begin
      if (!w_z_last) begin
        r_zi  <= r_zi + 1'b1;
        r_z_f <= r_z_f + Z_STEP;
      end else begin
        r_zi  <= '0;
        r_z_f <= Z_START;
        if (!w_x_last) begin
          r_xi  <= r_xi + 1'b1;
          r_x_f <= r_x_f + X_STEP;
        end
      end
    end
  end

  assign o_xi   = r_xi;
  assign o_zi   = r_zi;
  assign o_x_f  = r_x_f;
  assign o_z_f  = r_z_f;
  assign o_last = w_x_last & w_z_last;

endmodule

// File: rtl/bf_scan_scheduler.sv
// Frame sequencer above the delay-and-sum core: clear, launch and wait on
// each focal point with a watchdog, then hand the result out as a pixel.
module bf_scan_scheduler
  import bf_pkg::*;
#(
  parameter int                      SUM_WIDTH = 20,
  parameter int                      NUM_X     = 64,
  parameter int                      NUM_Z     = 128,
  parameter logic [COORD_WIDTH-1:0]  X_START   = 16'd0,
  parameter logic [COORD_WIDTH-1:0]  X_STEP    = 16'd1,
  parameter logic [COORD_WIDTH-1:0]  Z_START   = 16'd0,
  parameter logic [COORD_WIDTH-1:0]  Z_STEP    = 16'd1,
  parameter int                      TIMEOUT   = 1024,
  localparam int                     XW        = idx_w(NUM_X),
  localparam int                     ZW        = idx_w(NUM_Z)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   abort,
  output logic                   bf_clear,
  output logic                   bf_start,
  output logic [COORD_WIDTH-1:0] bf_x_f,
  output logic [COORD_WIDTH-1:0] bf_z_f,
  input  logic                   bf_valid,
  input  logic [SUM_WIDTH-1:0]   bf_result,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [SUM_WIDTH-1:0]   pix_data,
  output logic [XW-1:0]          pix_xi,
  output logic [ZW-1:0]          pix_zi,
  output logic                   pix_err,
  output logic                   pix_last,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   timeout_err
);

  localparam int            WW      = idx_w(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [WW-1:0]          r_wdog;
  logic [SUM_WIDTH-1:0]   r_pix_data;
  logic                   r_pix_err;
  logic                   r_timeout_err;
  logic                   r_abort_clr;
  logic                   w_load;
  logic                   w_step;
  logic                   w_last;
  logic                   w_wd_hit;
  logic                   w_accept;
  logic                   w_timeout;

  assign w_wd_hit  = (r_wdog == WD_LAST);
  assign w_accept  = (r_state == S_IDLE) && frame_start && !abort;
  assign w_timeout = (r_state == S_WAIT) && !abort && !bf_valid && w_wd_hit;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_next = S_CLEAR;
          w_load = 1'b1;
        end
      end
      S_CLEAR:  w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (bf_valid || w_wd_hit) w_next = S_EMIT;
      S_EMIT:   if (pix_ready) w_next = S_ADVANCE;
      S_ADVANCE: begin
        w_step = 1'b1;
        w_next = w_last ? S_FINISH : S_CLEAR;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort) begin
      w_next = S_IDLE;
      w_load = 1'b0;
      w_step = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_abort_clr <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_abort_clr <= abort;
    end
  end

  // Watchdog counts WAIT cycles; it only advances while no result is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog <= '0;
    end else if (r_state == S_LAUNCH) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT && !bf_valid && !w_wd_hit) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // A valid result on the last watchdog cycle still counts as a good pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix_data    <= '0;
      r_pix_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_WAIT && !abort && bf_valid) begin
        r_pix_data <= bf_result;
        r_pix_err  <= 1'b0;
      end else if (w_timeout) begin
        r_pix_data <= '0;
        r_pix_err  <= 1'b1;
      end
      if (w_accept) begin
        r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  bf_grid_counter #(
    .NUM_X   (NUM_X),
    .NUM_Z   (NUM_Z),
    .X_START (X_START),
    .X_STEP  (X_STEP),
    .Z_START (Z_START),
    .Z_STEP  (Z_STEP)
  ) u_grid (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_step (w_step),
    .o_xi   (pix_xi),
    .o_zi   (pix_zi),
    .o_x_f  (bf_x_f),
    .o_z_f  (bf_z_f),
    .o_last (w_last)
  );

  assign bf_clear    = (r_state == S_CLEAR) || r_abort_clr;
  assign bf_start    = (r_state == S_LAUNCH) && !abort;
  assign pix_valid   = (r_state == S_EMIT);
  assign pix_data    = r_pix_data;
  assign pix_err     = r_pix_err;
  assign pix_last    = w_last;
  assign busy        = (r_state != S_IDLE);
  assign frame_done  = (r_state == S_FINISH);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_bf_scan_scheduler.sv
// Bench for bf_scan_scheduler: emulated beamformer with per-point latency,
// randomized backpressure and a frame-level pixel scoreboard.
`timescale 1ns/1ps
module tb_bf_scan_scheduler;

  localparam int SW = 20;
  localparam int NX = 2;
  localparam int NZ = 3;
  localparam int NP = NX * NZ;
  localparam int TO = 8;
  localparam logic [15:0] XS0 = 16'd10;
  localparam logic [15:0] XST = 16'd4;
  localparam logic [15:0] ZS0 = 16'd100;
  localparam logic [15:0] ZST = 16'd2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic          abort = 1'b0;
  logic          bf_valid = 1'b0;
  logic          pix_ready = 1'b0;
  logic [SW-1:0] bf_result = '0;
  logic          bf_clear, bf_start, pix_valid, pix_err, pix_last;
  logic          busy, frame_done, timeout_err;
  logic [15:0]   bf_x_f, bf_z_f;
  logic [SW-1:0] pix_data;
  logic [0:0]    pix_xi;
  logic [1:0]    pix_zi;

  always #5 clk = ~clk;

  bf_scan_scheduler #(
    .SUM_WIDTH (SW), .NUM_X (NX), .NUM_Z (NZ),
    .X_START (XS0), .X_STEP (XST), .Z_START (ZS0), .Z_STEP (ZST),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk), .reset (reset), .frame_start (frame_start), .abort (abort),
    .bf_clear (bf_clear), .bf_start (bf_start), .bf_x_f (bf_x_f), .bf_z_f (bf_z_f),
    .bf_valid (bf_valid), .bf_result (bf_result),
    .pix_valid (pix_valid), .pix_ready (pix_ready), .pix_data (pix_data),
    .pix_xi (pix_xi), .pix_zi (pix_zi), .pix_err (pix_err), .pix_last (pix_last),
    .busy (busy), .frame_done (frame_done), .timeout_err (timeout_err)
  );

  typedef struct { int xi; int zi; int data; int err; int last; int emit_n; } pix_t;
  pix_t pq[$];
  int   lat_q[$];
  pix_t snap;
  int   dly[NP];
  int   rdy_mode = 0, stall_idx = -1;
  int   cyc = 0, n_clear = 0, n_start = 0, seq_bad = 0, clr_since = 0, unstable = 0;
  int   fd_cnt = 0, fd_cyc = 0, last_hs_cyc = 0, fd0 = 0;
  int   armed = 0, age = 0, cur_d = 0, launch_cyc = 0, in_emit = 0, emit_n = 0, rp = 0;
  int   checks = 0, errors = 0;

  // Point number from the coordinates the scheduler presents.
  function automatic int point_of(input logic [15:0] x, input logic [15:0] z);
    int xo, zo;
    xo = int'(x) - int'(XS0);
    zo = int'(z) - int'(ZS0);
    if (xo < 0 || zo < 0 || (xo % int'(XST)) != 0 || (zo % int'(ZST)) != 0) return -1;
    xo = xo / int'(XST);
    zo = zo / int'(ZST);
    if (xo >= NX || zo >= NZ) return -1;
    return xo * NZ + zo;
  endfunction

  // Beamformer emulation, pixel sink and event monitor, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      bf_valid = 1'b0; armed = 0; in_emit = 0;
    end else begin
      if (bf_clear) begin
        bf_valid = 1'b0; armed = 0; n_clear++; clr_since++;
      end else if (bf_start) begin
        rp = point_of(bf_x_f, bf_z_f);
        cur_d = (rp < 0) ? 5 : dly[rp];
        n_start++;
        if (clr_since != 1) seq_bad++;
        clr_since = 0; armed = 1; age = 0; launch_cyc = cyc;
        bf_result = SW'(bf_x_f) + SW'(bf_z_f);
      end else if (armed != 0) begin
        age++;
        if (cur_d != 0 && age >= cur_d) bf_valid = 1'b1;
      end
      if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
      if (pix_valid) begin
        if (in_emit == 0) begin
          in_emit = 1; emit_n = 0;
          snap = '{int'(pix_xi), int'(pix_zi), int'(pix_data), int'(pix_err), int'(pix_last), 0};
          lat_q.push_back(cyc - launch_cyc);
        end else if (snap.xi != int'(pix_xi) || snap.zi != int'(pix_zi) ||
                     snap.data != int'(pix_data) || snap.err != int'(pix_err) ||
                     snap.last != int'(pix_last)) begin
          unstable++;
        end
        emit_n++;
        case (rdy_mode)
          0:       pix_ready = 1'b1;
          1:       pix_ready = 1'($urandom_range(0, 1));
          2:       pix_ready = (pq.size() != stall_idx) || (emit_n > 7);
          default: pix_ready = 1'b0;
        endcase
        if (pix_ready) begin
          pq.push_back('{int'(pix_xi), int'(pix_zi), int'(pix_data), int'(pix_err), int'(pix_last), emit_n});
          in_emit = 0;
          if (pix_last) last_hs_cyc = cyc;
        end
      end else begin
        in_emit = 0;
        pix_ready = (rdy_mode == 0);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int mode, input int sidx);
    repeat (3) step;
    rdy_mode = mode; stall_idx = sidx;
    pq.delete(); lat_q.delete();
    n_clear = 0; n_start = 0; seq_bad = 0; clr_since = 0; unstable = 0; fd0 = fd_cnt;
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (fd_cnt == fd0 && n < 3000) begin step; n++; end
    chk({nm, "_done_in_time"}, 32'(fd_cnt != fd0), 1);
    repeat (2) step;
  endtask

  // Expected frame derived from the grid rules and each point's emulated latency.
  task automatic check_frame(input string nm, input int emit_chk, input int sidx);
    int any_to;
    any_to = 0;
    chk({nm, "_npix"}, pq.size(), NP);
    chk({nm, "_nlat"}, lat_q.size(), NP);
    for (int p = 0; p < NP && p < pq.size() && p < lat_q.size(); p++) begin
      int ok, ed;
      ok = (dly[p] >= 1 && dly[p] <= TO) ? 1 : 0;
      if (ok == 0) any_to = 1;
      ed = (ok != 0) ? (int'(XS0) + (p / NZ) * int'(XST) + int'(ZS0) + (p % NZ) * int'(ZST)) : 0;
      chk($sformatf("%s_xi%0d", nm, p),   pq[p].xi,   p / NZ);
      chk($sformatf("%s_zi%0d", nm, p),   pq[p].zi,   p % NZ);
      chk($sformatf("%s_data%0d", nm, p), pq[p].data, ed);
      chk($sformatf("%s_err%0d", nm, p),  pq[p].err,  1 - ok);
      chk($sformatf("%s_last%0d", nm, p), pq[p].last, 32'(p == NP - 1));
      chk($sformatf("%s_lat%0d", nm, p),  lat_q[p],   (ok != 0) ? dly[p] + 1 : TO + 1);
      if (emit_chk != 0)
        chk($sformatf("%s_emitn%0d", nm, p), pq[p].emit_n, (p == sidx) ? 8 : 1);
    end
    chk({nm, "_clears"},   n_clear, NP);
    chk({nm, "_starts"},   n_start, NP);
    chk({nm, "_clr_seq"},  seq_bad, 0);
    chk({nm, "_stable"},   unstable, 0);
    chk({nm, "_fd_count"}, fd_cnt - fd0, 1);
    chk({nm, "_fd_lat"},   fd_cyc - last_hs_cyc, 2);
    chk({nm, "_tmo_err"},  32'(timeout_err), any_to);
    chk({nm, "_idle"},     32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    int n;
    for (int p = 0; p < NP; p++) dly[p] = 5;
    reset = 1'b0;
    repeat (3) step;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_x_f", 32'(bf_x_f), 10);
    chk("rst_z_f", 32'(bf_z_f), 100);
    chk("rst_clear", 32'(bf_clear), 0);
    chk("rst_start", 32'(bf_start), 0);
    chk("rst_pvalid", 32'(pix_valid), 0);
    chk("rst_pdata", 32'(pix_data), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    reset = 1'b1;

    // Frame A: fixed latency 5, always ready.
    start_frame(0, -1);
    chk("A_busy", 32'(busy), 1);
    chk("A_clear_first", 32'(bf_clear), 1);
    chk("A_x0", 32'(bf_x_f), 10);
    chk("A_z0", 32'(bf_z_f), 100);
    wait_done("A");
    check_frame("A", 1, -1);

    // Frame B: random latency, pixel 2 stalled for 7 cycles.
    for (int p = 0; p < NP; p++) dly[p] = $urandom_range(1, 7);
    start_frame(2, 1);
    wait_done("B");
    check_frame("B", 1, 1);

    // Frame C: one dead point, one valid on the timeout cycle, one just late;
    // a frame_start while busy must be ignored.
    for (int p = 0; p < NP; p++) dly[p] = $urandom_range(1, 7);
    dly[1] = 0; dly[2] = 8; dly[3] = 9;
    start_frame(1, -1);
    repeat (12) step;
    chk("C_busy_mid", 32'(busy), 1);
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    wait_done("C");
    check_frame("C", 0, -1);

    // Frame D: timeout on the first point, then abort in WAIT of point 3.
    for (int p = 0; p < NP; p++) dly[p] = 5;
    dly[0] = 0;
    start_frame(0, -1);
    chk("D_tmo_cleared", 32'(timeout_err), 0);
    n = 0;
    while (!(pq.size() == 2 && bf_start) && n < 500) begin step; n++; end
    chk("D_reach_pt3", 32'(pq.size() == 2 && bf_start), 1);
    step;
    abort = 1'b1;
    step;
    abort = 1'b0;
    chk("D_ab_busy", 32'(busy), 0);
    chk("D_ab_clear", 32'(bf_clear), 1);
    chk("D_ab_pvalid", 32'(pix_valid), 0);
    chk("D_ab_start", 32'(bf_start), 0);
    chk("D_ab_fd", 32'(frame_done), 0);
    chk("D_ab_tmo_kept", 32'(timeout_err), 1);
    repeat (10) step;
    chk("D_ab_no_fd", fd_cnt - fd0, 0);
    chk("D_ab_idle", 32'(busy), 0);
    chk("D_ab_npix", pq.size(), 2);

    // abort and frame_start together in IDLE: abort wins.
    abort = 1'b1;
    frame_start = 1'b1;
    step;
    abort = 1'b0;
    frame_start = 1'b0;
    chk("AF_busy", 32'(busy), 0);
    chk("AF_clear", 32'(bf_clear), 1);
    step;
    chk("AF_busy2", 32'(busy), 0);

    // Frame E: restart after abort, random latency including timeouts.
    for (int p = 0; p < NP; p++) dly[p] = $urandom_range(0, 10);
    start_frame(1, -1);
    chk("E_x0", 32'(bf_x_f), 10);
    chk("E_z0", 32'(bf_z_f), 100);
    wait_done("E");
    check_frame("E", 0, -1);

    // Asynchronous reset while pixel (0,1) is stalled in EMIT.
    for (int p = 0; p < NP; p++) dly[p] = 3;
    start_frame(2, 1);
    n = 0;
    while (!(pq.size() == 1 && pix_valid) && n < 500) begin step; n++; end
    chk("R_in_emit", 32'(pq.size() == 1 && pix_valid), 1);
    repeat (2) step;
    #2;
    reset = 1'b0;
    #1;
    chk("R_busy", 32'(busy), 0);
    chk("R_pvalid", 32'(pix_valid), 0);
    chk("R_pdata", 32'(pix_data), 0);
    chk("R_pzi", 32'(pix_zi), 0);
    chk("R_pxi", 32'(pix_xi), 0);
    chk("R_z_f", 32'(bf_z_f), 100);
    chk("R_x_f", 32'(bf_x_f), 10);
    chk("R_pxerr", 32'(pix_err), 0);
    chk("R_clear", 32'(bf_clear), 0);
    step;
    reset = 1'b1;
    repeat (8) step;
    chk("R_no_fd", fd_cnt - fd0, 0);
    chk("R_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
